// File: rtl/pupil_bbox_tracker.sv
// Per-frame bounding box, centre and count of dark pixels from a binarised pixel stream.
// Optional ROI_EN macro restricts counting to the ROI_X0..ROI_X1 / ROI_Y0..ROI_Y1 window.
module pupil_bbox_tracker #(
    parameter int unsigned COORD_W    = 12,
    parameter int unsigned COUNT_W    = 20,
    parameter int unsigned MIN_PIXELS = 64,
    parameter int unsigned ROI_X0     = 0,
    parameter int unsigned ROI_X1     = 639,
    parameter int unsigned ROI_Y0     = 0,
    parameter int unsigned ROI_Y1     = 479
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iFVAL,
    input  logic               iDVAL,
    input  logic [9:0]         iDATA,
    output logic [COORD_W-1:0] oX_MIN,
    output logic [COORD_W-1:0] oX_MAX,
    output logic [COORD_W-1:0] oY_MIN,
    output logic [COORD_W-1:0] oY_MAX,
    output logic [COORD_W-1:0] oCX,
    output logic [COORD_W-1:0] oCY,
    output logic [COUNT_W-1:0] oCOUNT,
    output logic               oFOUND,
    output logic               oDONE
);

    typedef enum logic [1:0] {StIdle, StActive, StLatch} state_e;

    localparam logic [COORD_W-1:0] CoordMax = {COORD_W{1'b1}};
    localparam logic [COUNT_W-1:0] CountMax = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] MinPix   = COUNT_W'(MIN_PIXELS);

    state_e              state_q, state_d;
    logic                prev_fval_q, prev_dval_q;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
    logic [COUNT_W-1:0]  cnt_q, cnt_d;
    logic [COORD_W-1:0]  xmin_q, xmin_d, xmax_q, xmax_d;
    logic [COORD_W-1:0]  ymin_q, ymin_d, ymax_q, ymax_d;

    logic [COORD_W-1:0]  x_min_out_q, x_min_out_d, x_max_out_q, x_max_out_d;
    logic [COORD_W-1:0]  y_min_out_q, y_min_out_d, y_max_out_q, y_max_out_d;
    logic [COORD_W-1:0]  cx_q, cx_d, cy_q, cy_d;
    logic [COUNT_W-1:0]  count_out_q, count_out_d;
    logic                found_q, found_d;
    logic                done_q, done_d;

    logic                fval_rise, fval_fall, dval_fall;
    logic                start_frame, pix_en, line_end, latch_en;
    logic                dark, in_roi, count_pix;
    logic [COORD_W-1:0]  x_inc, y_inc;
    logic [COUNT_W-1:0]  cnt_inc;
    logic [COORD_W:0]    sum_x, sum_y;
    logic                unused_data;

    assign fval_rise = iFVAL & ~prev_fval_q;
    assign fval_fall = ~iFVAL & prev_fval_q;
    assign dval_fall = ~iDVAL & prev_dval_q;
    assign dark      = ~iDATA[9];
    assign unused_data = ^iDATA[8:0];

`ifdef ROI_EN
    localparam logic [COORD_W-1:0] RoiX0 = COORD_W'(ROI_X0);
    localparam logic [COORD_W-1:0] RoiX1 = COORD_W'(ROI_X1);
    localparam logic [COORD_W-1:0] RoiY0 = COORD_W'(ROI_Y0);
    localparam logic [COORD_W-1:0] RoiY1 = COORD_W'(ROI_Y1);

    assign in_roi = (x_q >= RoiX0) && (x_q <= RoiX1) && (y_q >= RoiY0) && (y_q <= RoiY1);
`else
    logic unused_roi;
    assign unused_roi = ^{ROI_X0, ROI_X1, ROI_Y0, ROI_Y1};
    assign in_roi     = 1'b1;
`endif

    assign count_pix = dark & in_roi;

    assign x_inc   = (x_q == CoordMax) ? x_q : x_q + 1'b1;
    assign y_inc   = (y_q == CoordMax) ? y_q : y_q + 1'b1;
    assign cnt_inc = (cnt_q == CountMax) ? cnt_q : cnt_q + 1'b1;

    // Extra bit keeps the centre exact when both bounds are near the top of the range.
    assign sum_x = {1'b0, xmin_q} + {1'b0, xmax_q};
    assign sum_y = {1'b0, ymin_q} + {1'b0, ymax_q};

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        pix_en      = 1'b0;
        line_end    = 1'b0;
        latch_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fval_rise) begin
                    state_d     = StActive;
                    start_frame = 1'b1;
                end
            end
            StActive: begin
                if (fval_fall) begin
                    state_d = StLatch;
                end else if (iDVAL) begin
                    pix_en = 1'b1;
                end else if (dval_fall) begin
                    line_end = 1'b1;
                end
            end
            StLatch: begin
                latch_en = 1'b1;
                state_d  = StIdle;
                if (fval_rise) begin
                    state_d     = StActive;
                    start_frame = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        cnt_d  = cnt_q;
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        if (start_frame) begin
            x_d    = '0;
            y_d    = '0;
            cnt_d  = '0;
            xmin_d = CoordMax;
            xmax_d = '0;
            ymin_d = CoordMax;
            ymax_d = '0;
        end else if (pix_en) begin
            if (count_pix) begin
                cnt_d  = cnt_inc;
                xmin_d = (x_q < xmin_q) ? x_q : xmin_q;
                xmax_d = (x_q > xmax_q) ? x_q : xmax_q;
                ymin_d = (y_q < ymin_q) ? y_q : ymin_q;
                ymax_d = (y_q > ymax_q) ? y_q : ymax_q;
            end
            x_d = x_inc;
        end else if (line_end) begin
            x_d = '0;
            y_d = y_inc;
        end
    end

    always_comb begin
        x_min_out_d = x_min_out_q;
        x_max_out_d = x_max_out_q;
        y_min_out_d = y_min_out_q;
        y_max_out_d = y_max_out_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        count_out_d = count_out_q;
        found_d     = found_q;
        done_d      = 1'b0;
        if (latch_en) begin
            // An empty frame reports a zero box rather than the all-ones seed values.
            if (cnt_q != '0) begin
                x_min_out_d = xmin_q;
                x_max_out_d = xmax_q;
                y_min_out_d = ymin_q;
                y_max_out_d = ymax_q;
                cx_d        = sum_x[COORD_W:1];
                cy_d        = sum_y[COORD_W:1];
            end else begin
                x_min_out_d = '0;
                x_max_out_d = '0;
                y_min_out_d = '0;
                y_max_out_d = '0;
                cx_d        = '0;
                cy_d        = '0;
            end
            count_out_d = cnt_q;
            found_d     = (cnt_q >= MinPix);
            done_d      = 1'b1;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= StIdle;
            // Seeded high so a frame already in progress at reset release is not seen as a start.
            prev_fval_q <= 1'b1;
            prev_dval_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymin_q      <= '0;
            ymax_q      <= '0;
            x_min_out_q <= '0;
            x_max_out_q <= '0;
            y_min_out_q <= '0;
            y_max_out_q <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            count_out_q <= '0;
            found_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_fval_q <= iFVAL;
            prev_dval_q <= iDVAL;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            x_min_out_q <= x_min_out_d;
            x_max_out_q <= x_max_out_d;
            y_min_out_q <= y_min_out_d;
            y_max_out_q <= y_max_out_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            count_out_q <= count_out_d;
            found_q     <= found_d;
            done_q      <= done_d;
        end
    end

    assign oX_MIN = x_min_out_q;
    assign oX_MAX = x_max_out_q;
    assign oY_MIN = y_min_out_q;
    assign oY_MAX = y_max_out_q;
    assign oCX    = cx_q;
    assign oCY    = cy_q;
    assign oCOUNT = count_out_q;
    assign oFOUND = found_q;
    assign oDONE  = done_q;

endmodule

// File: tb/tb_pupil_bbox_tracker.sv
// Directed bench for pupil_bbox_tracker on an 8x6 frame with 2-cycle line gaps.
// Instances: default parameters, MIN_PIXELS=9, and an ROI window x=3..7, y=0..5.
module tb_pupil_bbox_tracker;

    localparam int CW = 12;
    localparam int NW = 20;

    typedef int res_t [9];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fval = 1'b0;
    logic dval = 1'b0;
    logic [9:0] pix = 10'd1023;

    logic [CW-1:0] a_xmin, a_xmax, a_ymin, a_ymax, a_cx, a_cy;
    logic [NW-1:0] a_cnt;
    logic          a_found, a_done;
    logic [CW-1:0] n_xmin, n_xmax, n_ymin, n_ymax, n_cx, n_cy;
    logic [NW-1:0] n_cnt;
    logic          n_found, n_done;
    logic [CW-1:0] r_xmin, r_xmax, r_ymin, r_ymax, r_cx, r_cy;
    logic [NW-1:0] r_cnt;
    logic          r_found, r_done;

    int vec_cnt = 0;
    int err_cnt = 0;
    int done_a  = 0;
    string nm [9] = '{"x_min", "x_max", "y_min", "y_max", "cx", "cy", "count", "found", "done"};

    always #5 clk = ~clk;

    always @(posedge clk) if (a_done) done_a <= done_a + 1;

    pupil_bbox_tracker dut (
        .iCLK(clk), .iRST(rst), .iFVAL(fval), .iDVAL(dval), .iDATA(pix),
        .oX_MIN(a_xmin), .oX_MAX(a_xmax), .oY_MIN(a_ymin), .oY_MAX(a_ymax),
        .oCX(a_cx), .oCY(a_cy), .oCOUNT(a_cnt), .oFOUND(a_found), .oDONE(a_done)
    );

    pupil_bbox_tracker #(.MIN_PIXELS(9)) dut9 (
        .iCLK(clk), .iRST(rst), .iFVAL(fval), .iDVAL(dval), .iDATA(pix),
        .oX_MIN(n_xmin), .oX_MAX(n_xmax), .oY_MIN(n_ymin), .oY_MAX(n_ymax),
        .oCX(n_cx), .oCY(n_cy), .oCOUNT(n_cnt), .oFOUND(n_found), .oDONE(n_done)
    );

    pupil_bbox_tracker #(.ROI_X0(3), .ROI_X1(7), .ROI_Y0(0), .ROI_Y1(5)) droi (
        .iCLK(clk), .iRST(rst), .iFVAL(fval), .iDVAL(dval), .iDATA(pix),
        .oX_MIN(r_xmin), .oX_MAX(r_xmax), .oY_MIN(r_ymin), .oY_MAX(r_ymax),
        .oCX(r_cx), .oCY(r_cy), .oCOUNT(r_cnt), .oFOUND(r_found), .oDONE(r_done)
    );

    function automatic res_t snap_a();
        res_t v;
        v = '{int'(a_xmin), int'(a_xmax), int'(a_ymin), int'(a_ymax), int'(a_cx), int'(a_cy),
              int'(a_cnt), int'(a_found), int'(a_done)};
        return v;
    endfunction

    function automatic res_t snap_r();
        res_t v;
        v = '{int'(r_xmin), int'(r_xmax), int'(r_ymin), int'(r_ymax), int'(r_cx), int'(r_cy),
              int'(r_cnt), int'(r_found), int'(r_done)};
        return v;
    endfunction

    function automatic logic [47:0] box_mask(input int x0, input int x1, input int y0, input int y1);
        logic [47:0] m;
        m = '0;
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 8; x++)
                if (x >= x0 && x <= x1 && y >= y0 && y <= y1) m[y*8+x] = 1'b1;
        return m;
    endfunction

    task automatic cyc(input logic f, input logic d, input logic [9:0] p);
        @(negedge clk);
        fval = f;
        dval = d;
        pix  = p;
    endtask

    task automatic drive_row(input logic [47:0] mask, input int y, input int gap);
        for (int x = 0; x < 8; x++) cyc(1'b1, 1'b1, mask[y*8+x] ? 10'd0 : 10'd1023);
        repeat (gap) cyc(1'b1, 1'b0, 10'd1023);
    endtask

    task automatic start_frame();
        cyc(1'b1, 1'b0, 10'd1023);
        cyc(1'b1, 1'b0, 10'd1023);
    endtask

    task automatic test_reset();
        res_t got;
        res_t exp;
        rst  = 1'b1;
        fval = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        got = snap_a();
        exp = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 9; i++) begin
            vec_cnt++;
            if (got[i] !== exp[i]) begin
                err_cnt++;
                $display("FAIL reset %s: got %0d want %0d", nm[i], got[i], exp[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_block();
        res_t got;
        res_t exp;
        int d0;
        d0 = done_a;
        start_frame();
        for (int y = 0; y < 6; y++) drive_row(box_mask(2, 4, 1, 3), y, 2);
        cyc(1'b0, 1'b0, 10'd1023);
        @(posedge clk);
        @(posedge clk);
        #1;
        got = snap_a();
        exp = '{2, 4, 1, 3, 3, 2, 9, 0, 1};
        for (int i = 0; i < 9; i++) begin
            vec_cnt++;
            if (got[i] !== exp[i]) begin
                err_cnt++;
                $display("FAIL block %s: got %0d want %0d", nm[i], got[i], exp[i]);
            end
        end
        vec_cnt++;
        if (n_found !== 1'b1) begin
            err_cnt++;
            $display("FAIL block found_min9: got %0b want 1", n_found);
        end
        got = snap_r();
`ifdef ROI_EN
        exp = '{3, 4, 1, 3, 3, 2, 6, 0, 1};
`else
        exp = '{2, 4, 1, 3, 3, 2, 9, 0, 1};
`endif
        for (int i = 0; i < 9; i++) begin
            vec_cnt++;
            if (got[i] !== exp[i]) begin
                err_cnt++;
                $display("FAIL block_roi %s: got %0d want %0d", nm[i], got[i], exp[i]);
            end
        end
        @(posedge clk);
        #1;
        vec_cnt++;
        if (a_done !== 1'b0 || a_cnt !== 20'd9) begin
            err_cnt++;
            $display("FAIL block hold: got done=%0b count=%0d want done=0 count=9", a_done, a_cnt);
        end
        vec_cnt++;
        if (done_a - d0 !== 1) begin
            err_cnt++;
            $display("FAIL block done_pulses: got %0d want 1", done_a - d0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        start_frame();
        drive_row(box_mask(2, 4, 1, 3), 0, 2);
        drive_row(box_mask(2, 4, 1, 3), 1, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        vec_cnt++;
        if (a_cnt !== '0 || a_xmin !== '0) begin
            err_cnt++;
            $display("FAIL midreset async_clear: got count=%0d x_min=%0d want 0 0", a_cnt, a_xmin);
        end
        @(negedge clk);
        rst = 1'b0;
        d0 = done_a;
        for (int y = 2; y < 6; y++) drive_row(box_mask(2, 4, 1, 3), y, 2);
        cyc(1'b0, 1'b0, 10'd1023);
        repeat (4) @(posedge clk);
        #1;
        vec_cnt++;
        if (done_a !== d0) begin
            err_cnt++;
            $display("FAIL midreset no_done: got %0d pulses want 0", done_a - d0);
        end
        vec_cnt++;
        if (a_cnt !== '0 || a_xmax !== '0 || a_found !== 1'b0) begin
            err_cnt++;
            $display("FAIL midreset outputs: got count=%0d x_max=%0d found=%0b want 0 0 0",
                     a_cnt, a_xmax, a_found);
        end
        start_frame();
        for (int y = 0; y < 6; y++) drive_row(box_mask(2, 4, 1, 3), y, 2);
        cyc(1'b0, 1'b0, 10'd1023);
        @(posedge clk);
        @(posedge clk);
        #1;
        vec_cnt++;
        if (a_done !== 1'b1 || a_cnt !== 20'd9 || a_xmin !== 12'd2 || a_ymax !== 12'd3) begin
            err_cnt++;
            $display("FAIL midreset next_frame: got done=%0b count=%0d x_min=%0d y_max=%0d want 1 9 2 3",
                     a_done, a_cnt, a_xmin, a_ymax);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_all_bright();
        res_t got;
        res_t exp;
        int d0;
        d0 = done_a;
        start_frame();
        for (int y = 0; y < 6; y++) drive_row(48'd0, y, 2);
        cyc(1'b0, 1'b0, 10'd1023);
        @(posedge clk);
        @(posedge clk);
        #1;
        got = snap_a();
        exp = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 9; i++) begin
            vec_cnt++;
            if (got[i] !== exp[i]) begin
                err_cnt++;
                $display("FAIL bright %s: got %0d want %0d", nm[i], got[i], exp[i]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++;
        if (done_a - d0 !== 1 || a_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL bright done_once: got %0d pulses done=%0b want 1 0", done_a - d0, a_done);
        end
    endtask

    task automatic test_last_pixel();
        res_t got;
        res_t exp;
        logic [47:0] m;
        m = '0;
        m[47] = 1'b1;
        start_frame();
        for (int y = 0; y < 6; y++) drive_row(m, y, (y == 5) ? 0 : 2);
        cyc(1'b0, 1'b0, 10'd1023);
        @(posedge clk);
        #1;
        vec_cnt++;
        if (a_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL lastpix early_done: got %0b want 0", a_done);
        end
        @(posedge clk);
        #1;
        got = snap_a();
        exp = '{7, 7, 5, 5, 7, 5, 1, 0, 1};
        for (int i = 0; i < 9; i++) begin
            vec_cnt++;
            if (got[i] !== exp[i]) begin
                err_cnt++;
                $display("FAIL lastpix %s: got %0d want %0d", nm[i], got[i], exp[i]);
            end
        end
        got = snap_r();
        for (int i = 0; i < 9; i++) begin
            vec_cnt++;
            if (got[i] !== exp[i]) begin
                err_cnt++;
                $display("FAIL lastpix_roi %s: got %0d want %0d", nm[i], got[i], exp[i]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        res_t got;
        res_t exp;
        logic [47:0] m;
        m = '0;
        m[0] = 1'b1;
        start_frame();
        for (int y = 0; y < 6; y++) drive_row(box_mask(2, 4, 1, 3), y, 2);
        cyc(1'b0, 1'b0, 10'd1023);
        cyc(1'b1, 1'b0, 10'd1023);
        @(posedge clk);
        #1;
        got = snap_a();
        exp = '{2, 4, 1, 3, 3, 2, 9, 0, 1};
        for (int i = 0; i < 9; i++) begin
            vec_cnt++;
            if (got[i] !== exp[i]) begin
                err_cnt++;
                $display("FAIL b2b_first %s: got %0d want %0d", nm[i], got[i], exp[i]);
            end
        end
        cyc(1'b1, 1'b0, 10'd1023);
        for (int y = 0; y < 6; y++) drive_row(m, y, 2);
        cyc(1'b0, 1'b0, 10'd1023);
        @(posedge clk);
        @(posedge clk);
        #1;
        got = snap_a();
        exp = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
        for (int i = 0; i < 9; i++) begin
            vec_cnt++;
            if (got[i] !== exp[i]) begin
                err_cnt++;
                $display("FAIL b2b_second %s: got %0d want %0d", nm[i], got[i], exp[i]);
            end
        end
        got = snap_r();
`ifdef ROI_EN
        exp = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
`endif
        for (int i = 0; i < 9; i++) begin
            vec_cnt++;
            if (got[i] !== exp[i]) begin
                err_cnt++;
                $display("FAIL b2b_second_roi %s: got %0d want %0d", nm[i], got[i], exp[i]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_block();
        test_reset_mid_frame();
        test_all_bright();
        test_last_pixel();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pupil_bbox_tracker.md
Name: pupil_bbox_tracker

Overview:
- Sits directly downstream of the binary thresholding stage in the pupil-search pipeline.
- Consumes the per-pixel binarised stream (0 = dark, 1023 = bright) with its data-valid strobe, plus the camera frame-valid.
- Tracks raster coordinates and accumulates, per frame, the bounding box and count of dark (pupil-candidate) pixels.
- At frame end it latches box, centre and count, and pulses a done strobe for the overlay and servo logic.

Parameters:
- COORD_W, 12, width of the x/y coordinate counters and box outputs.
- COUNT_W, 20, width of the dark-pixel counter.
- MIN_PIXELS, 64, minimum dark-pixel count for oFOUND to assert.
- ROI_X0, 0, ROI left edge inclusive (used only with ROI_EN).
- ROI_X1, 639, ROI right edge inclusive (used only with ROI_EN).
- ROI_Y0, 0, ROI top edge inclusive (used only with ROI_EN).
- ROI_Y1, 479, ROI bottom edge inclusive (used only with ROI_EN).

Ports:
- iCLK  input  1  pixel clock; all logic on rising edge.
- iRST  input  1  asynchronous, active-high reset.
- iFVAL  input  1  frame valid; high for the whole active frame.
- iDVAL  input  1  pixel valid from the binarisation stage.
- iDATA  input  10  binarised pixel; dark when iDATA[9]==0.
- oX_MIN  output  COORD_W  latched left edge of the dark box.
- oX_MAX  output  COORD_W  latched right edge.
- oY_MIN  output  COORD_W  latched top edge.
- oY_MAX  output  COORD_W  latched bottom edge.
- oCX  output  COORD_W  latched centre x = (oX_MIN+oX_MAX)>>1.
- oCY  output  COORD_W  latched centre y = (oY_MIN+oY_MAX)>>1.
- oCOUNT  output  COUNT_W  latched dark-pixel count.
- oFOUND  output  1  latched flag: oCOUNT >= MIN_PIXELS.
- oDONE  output  1  one-cycle pulse when the latched outputs update.

Behaviour:
- Reset (iRST high, async): all outputs 0, state IDLE, internal accumulators and counters cleared. Reset mid-frame discards that frame; no oDONE is produced for it.
- Registered prev_fval and prev_dval are used for edge detection.
- States:
  - IDLE: wait for an iFVAL rising edge (prev 0, now 1), then go to ACTIVE with x=0, y=0, count=0, xmin/ymin=all-ones, xmax/ymax=0. Leaving reset with iFVAL already high stays in IDLE until the next rising edge; partial frames are never measured.
  - ACTIVE:
    - Each cycle with iDVAL=1: pixel at (x,y); if dark, count++ (saturating at all-ones), and each bound updates with min/max against x,y. Then x++ (saturating).
    - iDVAL falling edge: x=0, y++ (saturating).
    - iFVAL falling edge: go to LATCH. Pixels presented with iDVAL=1 in that same cycle are ignored.
  - LATCH (one cycle):
    - If count>0: copy the bounds to the outputs and compute oCX/oCY using a COORD_W+1-bit sum.
    - If count==0: box and centre outputs are 0.
    - oCOUNT <= count; oFOUND <= (count >= MIN_PIXELS); oDONE=1 this cycle only; then go to IDLE.
    - An iFVAL rising edge coinciding with LATCH is honoured: the next state is ACTIVE with the accumulators cleared.
- Latency: the iFVAL falling edge sampled at edge N makes the outputs valid and oDONE high after edge N+1.
- Outputs hold their values between oDONE pulses.
- iDVAL while in IDLE is ignored.

Optional Feature:
- Macro ROI_EN.
- Defined: a dark pixel is counted only if ROI_X0<=x<=ROI_X1 and ROI_Y0<=y<=ROI_Y1. Coordinates remain full-frame.
- Undefined: every dark pixel with iDVAL=1 is counted, and the ROI parameters are unused.

Test Plan:
- Reset mid-frame: assert iRST during ACTIVE, release, continue the frame → no oDONE for that frame, outputs stay 0. The next full frame is measured normally.
- 8x6 frame, 2-cycle line gaps, dark block x=2..4, y=1..3 → oX_MIN=2, oX_MAX=4, oY_MIN=1, oY_MAX=3, oCX=3, oCY=2, oCOUNT=9. oFOUND=0 with MIN_PIXELS=64; oFOUND=1 with MIN_PIXELS=9.
- All-bright frame → oDONE pulses once; box, centre and count are 0; oFOUND=0.
- Single dark pixel at the last pixel of the last line, iFVAL dropping the cycle after → box=(7,7,5,5), oCOUNT=1, oDONE exactly one cycle after the iFVAL fall is sampled.
- Back-to-back frames with iFVAL rising in the LATCH cycle → the second frame's results are independent of the first (dark block at x=0, y=0 only gives box 0,0,0,0, count 1).
- ROI_EN defined, ROI x=3..7, y=0..5, dark block from the second scenario → oX_MIN=3, oX_MAX=4, oCOUNT=6. Without ROI_EN, the results match the second scenario.
